// File: rtl/wb_timer_mc.sv
// Wishbone-mapped multi-channel compare timer. Every channel runs off one shared
// prescaler tick, and a channel raises its status bit when COUNT reaches COMPARE.
module wb_timer_mc #(
  parameter int                       WB_DATA_WIDTH   = 32,
  parameter int                       WB_ADDR_WIDTH   = 32,
  parameter logic [WB_ADDR_WIDTH-1:0] WB_ADDR_START   = 32'h0000_0000,
  parameter int                       NUM_CHANNELS    = 4,
  parameter int                       PRESCALER_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
  input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic                     wb_we_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  output logic                     wb_ack_o,
  output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
  output logic                     irq_o
);
  localparam int W  = WB_DATA_WIDTH;
  localparam int N  = NUM_CHANNELS;
  localparam int PW = PRESCALER_WIDTH;
  localparam logic [WB_ADDR_WIDTH-1:0] SPAN = WB_ADDR_WIDTH'(16 + 16 * N);

  logic [WB_ADDR_WIDTH-1:0] off;
  logic                     borrow;
  logic                     in_win, accept, wr;
  logic [5:0]               word;

  logic [PW-1:0] prescale_q, prescale_d, pcnt_q, pcnt_d;
  logic          tick;
  logic [N-1:0]  stat_q, stat_d, ien_q, ien_d, en_q, en_d, per_q, per_d;
  logic [N-1:0]  hw_set, sw_clr;
  logic [W-1:0]  cmp_q [N];
  logic [W-1:0]  cmp_d [N];
  logic [W-1:0]  cnt_q [N];
  logic [W-1:0]  cnt_d [N];
  logic          ack_q;
  logic [W-1:0]  dat_q, dat_d, rdata;

  // The borrow bit flags addresses below the window base.
  assign {borrow, off} = {1'b0, wb_addr_i} - {1'b0, WB_ADDR_START};
  assign in_win = !borrow && (off < SPAN);
  assign accept = wb_cyc_i && wb_stb_i && in_win && !ack_q;
  assign wr     = accept && wb_we_i;
  assign word   = off[7:2];

  always_comb begin
    rdata = '0;
    case (word)
      6'd0:    rdata = W'(prescale_q);
      6'd1:    rdata = W'(stat_q);
      6'd2:    rdata = W'(ien_q);
      default: ;
    endcase
    for (int n = 0; n < N; n++) begin
      if (word == 6'(4 + 4 * n)) rdata = W'({per_q[n], en_q[n]});
      if (word == 6'(5 + 4 * n)) rdata = cmp_q[n];
      if (word == 6'(6 + 4 * n)) rdata = cnt_q[n];
    end
  end

  always_comb begin
    tick       = (pcnt_q == prescale_q);
    prescale_d = prescale_q;
    pcnt_d     = tick ? '0 : pcnt_q + PW'(1);
    ien_d      = ien_q;
    en_d       = en_q;
    per_d      = per_q;
    hw_set     = '0;
    sw_clr     = '0;
    for (int n = 0; n < N; n++) begin
      cmp_d[n] = cmp_q[n];
      cnt_d[n] = cnt_q[n];
      if (tick && en_q[n]) begin
        if (cnt_q[n] == cmp_q[n]) begin
          hw_set[n] = 1'b1;
          if (per_q[n]) cnt_d[n] = '0;
          else          en_d[n]  = 1'b0;
        end else begin
          cnt_d[n] = cnt_q[n] + W'(1);
        end
      end
    end
    // Bus writes are applied after the tick update so software wins on COUNT/CTRL.
    if (wr) begin
      case (word)
        6'd0: begin
          prescale_d = wb_dat_i[PW-1:0];
          pcnt_d     = '0;
        end
        6'd1:    sw_clr = wb_dat_i[N-1:0];
        6'd2:    ien_d  = wb_dat_i[N-1:0];
        default: ;
      endcase
      for (int n = 0; n < N; n++) begin
        if (word == 6'(4 + 4 * n)) begin
          en_d[n]  = wb_dat_i[0];
          per_d[n] = wb_dat_i[1];
        end
        if (word == 6'(5 + 4 * n)) cmp_d[n] = wb_dat_i;
        if (word == 6'(6 + 4 * n)) cnt_d[n] = wb_dat_i;
      end
    end
    stat_d = (stat_q & ~sw_clr) | hw_set;
    dat_d  = (accept && !wb_we_i) ? rdata : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prescale_q <= '0;
      pcnt_q     <= '0;
      stat_q     <= '0;
      ien_q      <= '0;
      en_q       <= '0;
      per_q      <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      for (int n = 0; n < N; n++) begin
        cmp_q[n] <= '0;
        cnt_q[n] <= '0;
      end
    end else begin
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      stat_q     <= stat_d;
      ien_q      <= ien_d;
      en_q       <= en_d;
      per_q      <= per_d;
      ack_q      <= accept;
      dat_q      <= dat_d;
      for (int n = 0; n < N; n++) begin
        cmp_q[n] <= cmp_d[n];
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = |(stat_q & ien_q);

endmodule

// File: tb/tb_wb_timer_mc.sv
// Randomised and directed bench for wb_timer_mc. A behavioural register-map model
// predicts ack, read data and irq on every clock.
module tb_wb_timer_mc;
  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          SPAN = 16 + 16 * N;

  logic        clk = 1'b0;
  logic        rst, we, cyc, stb;
  logic [31:0] addr, dat_i;
  logic        ack, irq;
  logic [31:0] dat_o;

  always #5 clk = ~clk;

  wb_timer_mc #(
    .WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(32), .WB_ADDR_START(BASE),
    .NUM_CHANNELS(N), .PRESCALER_WIDTH(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .wb_dat_i(dat_i), .wb_addr_i(addr), .wb_we_i(we),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(ack), .wb_dat_o(dat_o), .irq_o(irq)
  );

  int n_vec = 0;
  int n_err = 0;

  int unsigned m_psc, m_pcnt, m_stat, m_ien;
  bit          m_en  [N];
  bit          m_per [N];
  bit [31:0]   m_cmp [N];
  bit [31:0]   m_cnt [N];
  bit          m_ack;
  bit [31:0]   m_dat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [31:0] m_read(input int r);
    int ch, f;
    if (r == 0) return m_psc;
    if (r == 1) return m_stat;
    if (r == 2) return m_ien;
    if (r < 4) return 0;
    ch = (r - 4) / 4;
    f  = (r - 4) % 4;
    case (f)
      0:       return {30'd0, m_per[ch], m_en[ch]};
      1:       return m_cmp[ch];
      2:       return m_cnt[ch];
      default: return 0;
    endcase
  endfunction

  // Predict the register state after the coming edge, take the edge, then compare.
  task automatic cycle();
    int unsigned psc, pcnt, stat, ien, clr, set;
    bit          en [N];
    bit          per[N];
    bit [31:0]   cmp[N];
    bit [31:0]   cnt[N];
    bit          ack_n, tick, inwin;
    bit [31:0]   dat_n;
    longint      off;
    int          r, ch, f;
    psc = m_psc; pcnt = m_pcnt; ien = m_ien; clr = 0; set = 0;
    en = m_en; per = m_per; cmp = m_cmp; cnt = m_cnt;
    ack_n = 0; dat_n = 0; stat = m_stat;
    if (rst) begin
      psc = 0; pcnt = 0; ien = 0; stat = 0;
      for (int i = 0; i < N; i++) begin
        en[i] = 0; per[i] = 0; cmp[i] = 0; cnt[i] = 0;
      end
    end else begin
      tick = (m_pcnt == m_psc);
      pcnt = tick ? 0 : m_pcnt + 1;
      for (int i = 0; i < N; i++) begin
        if (tick && m_en[i]) begin
          if (m_cnt[i] == m_cmp[i]) begin
            set |= (1 << i);
            if (m_per[i]) cnt[i] = 0;
            else          en[i]  = 0;
          end else begin
            cnt[i] = m_cnt[i] + 1;
          end
        end
      end
      off   = longint'(addr) - longint'(BASE);
      inwin = (off >= 0) && (off < SPAN);
      if (cyc && stb && inwin && !m_ack) begin
        ack_n = 1;
        r     = int'(off / 4);
        if (!we) begin
          dat_n = m_read(r);
        end else if (r == 0) begin
          psc  = dat_i & 32'hFF;
          pcnt = 0;
        end else if (r == 1) begin
          clr = dat_i & 32'hF;
        end else if (r == 2) begin
          ien = dat_i & 32'hF;
        end else if (r >= 4) begin
          ch = (r - 4) / 4;
          f  = (r - 4) % 4;
          if (f == 0) begin
            en[ch]  = dat_i[0];
            per[ch] = dat_i[1];
          end
          if (f == 1) cmp[ch] = dat_i;
          if (f == 2) cnt[ch] = dat_i;
        end
      end
      stat = (m_stat & ~clr) | set;
    end
    @(posedge clk);
    #1;
    m_psc = psc; m_pcnt = pcnt; m_ien = ien; m_stat = stat;
    m_en = en; m_per = per; m_cmp = cmp; m_cnt = cnt;
    m_ack = ack_n; m_dat = dat_n;
    chk("ack", ack, m_ack);
    chk("dat", dat_o, m_dat);
    chk("irq", irq, ((m_stat & m_ien) != 0));
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; dat_i = d; we = 1; cyc = 1; stb = 1;
    cycle();
    cyc = 0; stb = 0; we = 0;
    cycle();
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; we = 0; cyc = 1; stb = 1;
    d = 'x;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (ack === 1'b1) begin
        d = dat_o;
        break;
      end
    end
    cyc = 0; stb = 0;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic logic [31:0] ch_reg(input int ch, input int f);
    return BASE + 32'h10 + 32'h10 * ch + 4 * f;
  endfunction

  logic [31:0] rd;
  int          waited, r;

  initial begin
    rst = 1; we = 0; cyc = 0; stb = 0; addr = BASE; dat_i = 0;
    idle(2);
    chk("rst_ack", ack, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_irq", irq, 0);
    rst = 0;

    // Periodic channel 0 with compare 5 and no prescaling.
    wb_write(BASE + 0, 0);
    wb_write(ch_reg(0, 1), 5);
    wb_write(BASE + 8, 1);
    wb_write(ch_reg(0, 0), 3);
    idle(10);
    wb_read(BASE + 4, rd);
    chk("p0_status", rd, 1);
    wb_read(ch_reg(0, 0), rd);
    chk("p0_ctrl", rd, 3);
    // Sweep the W1C across every phase of the 6-cycle period to hit the set/clear collision.
    for (int d = 0; d < 6; d++) begin
      idle(d);
      wb_write(BASE + 4, 1);
    end
    wb_write(ch_reg(0, 0), 0);
    wb_write(BASE + 4, 32'hF);
    wb_read(BASE + 4, rd);
    chk("p0_cleared", rd, 0);

    // One-shot channel 1 behind a divide-by-4 prescaler.
    wb_write(BASE + 0, 3);
    wb_write(ch_reg(1, 1), 2);
    wb_write(ch_reg(1, 0), 1);
    idle(40);
    wb_read(BASE + 4, rd);
    chk("os_status", rd, 2);
    wb_read(ch_reg(1, 0), rd);
    chk("os_ctrl", rd, 0);
    wb_read(ch_reg(1, 2), rd);
    chk("os_count", rd, 2);
    wb_write(BASE + 4, 2);
    idle(30);
    wb_read(BASE + 4, rd);
    chk("os_no_reset", rd, 0);

    // Channel 2 counting through the 32-bit wrap.
    wb_write(BASE + 0, 0);
    wb_write(ch_reg(2, 2), 32'hFFFF_FFFF);
    wb_write(ch_reg(2, 1), 3);
    wb_write(ch_reg(2, 0), 1);
    idle(20);
    wb_read(ch_reg(2, 2), rd);
    chk("wrap_count", rd, 3);
    wb_read(BASE + 4, rd);
    chk("wrap_status", rd, 4);
    wb_write(BASE + 4, 4);

    // Unmapped hole inside the window, then addresses on both sides of it.
    wb_read(BASE + 32'h0C, rd);
    chk("hole_read", rd, 0);
    addr = BASE + SPAN; we = 0; cyc = 1; stb = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("above_noack", ack, 0);
    end
    addr = BASE - 4;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("below_noack", ack, 0);
    end
    addr = BASE + 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("b2b_ack", ack, (i % 2 == 0));
    end
    cyc = 0; stb = 0;
    cycle();

    // Reset while an interrupt is pending.
    wb_write(ch_reg(0, 1), 1);
    wb_write(BASE + 8, 1);
    wb_write(ch_reg(0, 0), 3);
    waited = 0;
    while (irq !== 1'b1 && waited < 20) begin
      cycle();
      waited++;
    end
    chk("pre_rst_irq", irq, 1);
    rst = 1;
    cycle();
    rst = 0;
    chk("post_rst_irq", irq, 0);
    chk("post_rst_ack", ack, 0);
    for (int w = 0; w < 4 + 4 * N; w++) begin
      wb_read(BASE + 4 * w, rd);
      chk("post_rst_reg", rd, 0);
    end

    // Random bus traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      cyc = ($urandom_range(0, 3) != 0);
      stb = cyc && ($urandom_range(0, 1) == 1);
      we  = ($urandom_range(0, 1) == 1);
      r   = $urandom_range(0, 99);
      if (r < 3)      addr = BASE + SPAN + 4 * $urandom_range(0, 7);
      else if (r < 5) addr = BASE - 4;
      else            addr = BASE + 4 * $urandom_range(0, SPAN / 4 - 1);
      dat_i = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 7);
      cycle();
    end
    rst = 0; cyc = 0; stb = 0; we = 0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wb_timer_mc.md
WB_TIMER_MC -- requirements
Module: wb_timer_mc

Interface
REQ-001 SHALL have parameter WB_DATA_WIDTH, default 32, data bus and counter width (16..32).
REQ-002 SHALL have parameter WB_ADDR_WIDTH, default 32, address bus width.
REQ-003 SHALL have parameter WB_ADDR_START, default 32'h00000000, base byte address of register window.
REQ-004 SHALL have parameter NUM_CHANNELS, default 4, number of independent timer channels (1..8).
REQ-005 SHALL have parameter PRESCALER_WIDTH, default 8, width of shared prescaler.
REQ-006 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port wb_dat_i  input  WB_DATA_WIDTH  write data.
REQ-009 SHALL have port wb_addr_i  input  WB_ADDR_WIDTH  byte address.
REQ-010 SHALL have port wb_we_i  input  1  write enable.
REQ-011 SHALL have port wb_cyc_i  input  1  bus cycle.
REQ-012 SHALL have port wb_stb_i  input  1  strobe.
REQ-013 SHALL have port wb_ack_o  output  1  transfer acknowledge.
REQ-014 SHALL have port wb_dat_o  output  WB_DATA_WIDTH  read data, valid with wb_ack_o.
REQ-015 SHALL have port irq_o  output  1  OR of enabled pending channel interrupts.

Function
REQ-016 Register map (byte offsets from WB_ADDR_START, 4-byte stride): 0x00 PRESCALE, 0x04 IRQ_STATUS, 0x08 IRQ_ENABLE; channel n at 0x10+0x10*n: +0x0 CTRL (bit0 EN, bit1 PERIODIC), +0x4 COMPARE, +0x8 COUNT.
REQ-017 Window SHALL span WB_ADDR_START to WB_ADDR_START+0x10+0x10*NUM_CHANNELS-1; unmapped offsets inside read 0, ignore writes, still ack.
REQ-018 Addresses outside window SHALL produce no ack and no register change.
REQ-019 Access accepted when wb_cyc_i & wb_stb_i & in-window & !wb_ack_o; wb_ack_o SHALL pulse high exactly one cycle later, one cycle wide.
REQ-020 Write side effects SHALL take effect on the acceptance edge; wb_dat_o SHALL be registered at acceptance and held 0 when wb_ack_o low.
REQ-021 Unimplemented register bits SHALL read 0; IRQ_STATUS/IRQ_ENABLE use bits [NUM_CHANNELS-1:0].
REQ-022 Prescaler counter SHALL count 0..PRESCALE; tick asserts for one cycle when counter==PRESCALE, counter returns to 0; PRESCALE=0 gives tick every cycle.
REQ-023 Write to PRESCALE SHALL also clear prescaler counter to 0.
REQ-024 On tick with EN=1: if COUNT==COMPARE, set IRQ_STATUS[n]; PERIODIC=1 loads COUNT=0; PERIODIC=0 holds COUNT and clears EN.
REQ-025 On tick with EN=1 and COUNT!=COMPARE, COUNT SHALL increment, wrapping 2^WB_DATA_WIDTH-1 to 0.
REQ-026 EN=0 SHALL freeze COUNT; no status set.
REQ-027 IRQ_STATUS SHALL be write-1-to-clear; hardware set in same cycle as software clear of same bit: set wins.
REQ-028 Software write to COUNT or CTRL in same cycle as tick update SHALL win over hardware update.
REQ-029 irq_o SHALL equal |(IRQ_STATUS & IRQ_ENABLE), derived from registers only, no combinational path from bus inputs.
REQ-030 Channels SHALL be fully independent except shared prescaler tick.

Reset
REQ-031 While rst_i high at clock edge: all registers, prescaler counter, COUNT, CTRL, COMPARE, IRQ_STATUS, IRQ_ENABLE = 0; wb_ack_o=0, wb_dat_o=0, irq_o=0.
REQ-032 Reset during a bus access SHALL drop the pending ack; no write completes.

Verification
REQ-033 PRESCALE=0, ch0 COMPARE=5, CTRL=3, IRQ_ENABLE=1 -> IRQ_STATUS[0] set 6 ticks after enable, COUNT 0..5 then 0, irq_o=1 every 6 cycles until W1C.
REQ-034 PRESCALE=3, ch1 COMPARE=2, CTRL=1 -> status set after 12 clocks, EN reads 0, COUNT holds 2, no further sets.
REQ-035 W1C of IRQ_STATUS[0] on the cycle hardware sets bit 0 -> bit remains 1, irq_o stays 1.
REQ-036 COUNT=FFFFFFFF, COMPARE=3, EN=1 -> COUNT wraps to 0, status set at COUNT==3.
REQ-037 Read offset 0x0C and offset beyond window -> first acks with 0 one cycle later, second never acks; back-to-back held stb yields ack every second cycle.
REQ-038 rst_i asserted mid-count with irq_o=1 -> next cycle all registers read 0, irq_o=0.
